mycpu_mem_stage: RTL and testbench
==================================

# mycpu_mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits between EX and WB and holds the MS pipeline register with a valid/allowin handshake. It issues data-SRAM requests, building byte strobes and lane-replicated write data for SB/SH/SW/SWL/SWR. It captures the one-cycle-latency SRAM read data and right-aligns byte/half loads so that WB sign/zero-extends from bit 0.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- resetn  in  1  reset, synchronous, active-low
- es_to_ms_valid  in  1  EX holds a valid instruction for MS
- ms_allowin  out  1  MS can accept this cycle
- es_alu_result  in  32  ALU result / effective address
- es_store_data  in  32  rt value for stores
- es_mode  in  6  [5]=load, [4]=store, [3:1]=size (000 B, 001 H, 010 W, 011 left, 100 right), [0]=sign-extend
- es_c5  in  1  register write-back enable
- es_dest  in  5  destination register
- ms_to_ws_valid  out  1  MS output valid
- ws_allowin  in  1  WB can accept
- ms_alu_result  out  32; ms_mode  out  6; ms_c5  out  1; ms_dest  out  5  registered payload
- ms_rdata  out  32  aligned load data for WB
- ms_adel, ms_ades  out  1  load/store address error flags
- data_sram_en  out  1; data_sram_wen  out  4; data_sram_addr  out  32; data_sram_wdata  out  32
- data_sram_rdata  in  32  valid exactly one cycle after an enabled read

## Operation
- Handover: hs_in = es_to_ms_valid & ms_allowin. ms_ready_go = 1. ms_allowin = !ms_valid | ws_allowin. ms_to_ws_valid = ms_valid.
- On hs_in, all es_* payload is registered and ms_valid is set. If !hs_in and ws_allowin, ms_valid is cleared.
- SRAM request is combinational in the handover cycle:
  - data_sram_en = hs_in & (mode[5] | mode[4]).
  - data_sram_addr = {es_alu_result[31:2], 2'b00}.
- Stores, with a = addr[1:0] and rt = es_store_data:
  - SB: wen = 0001<<a; wdata = {4{rt[7:0]}}.
  - SH: wen = 0011<<a; wdata = {2{rt[15:0]}}.
  - SW: wen = 1111; wdata = rt.
  - SWL: wen = 0001/0011/0111/1111 for a = 0..3; wdata = rt >> 8*(3-a).
  - SWR: wen = 1111/1110/1100/1000; wdata = rt << 8*a.
  - Loads and non-memory instructions: wen = 0000.
- Load data:
  - ms_first is set on hs_in and cleared the next cycle.
  - In the ms_first cycle, data_sram_rdata is captured into rdata_buf.
  - Raw word = ms_first ? data_sram_rdata : rdata_buf.
  - Size 000/001: ms_rdata = raw >> 8*ms_alu_result[1:0].
  - Size 010/011/100: ms_rdata = raw unshifted; WB merges LWL/LWR.
  - Non-loads: ms_rdata = 0.
- Exception flags are valid only while ms_valid, and are 0 otherwise (see Configuration).

## Timing
- Reset (resetn low at a clk edge) clears ms_valid, ms_first, rdata_buf, every payload register, and ms_adel/ms_ades.
- Reset mid-transfer drops the in-flight instruction; no SRAM enable is produced while resetn is low.
- Latency: issue at cycle N (hs_in), data at N+1 (ms_first). MS can forward at N+1 if ws_allowin.
- WB stall: ms_rdata comes from rdata_buf from N+2 onward and stays stable until handover.
- Back-to-back: hs_in with ms_valid & ws_allowin in the same cycle replaces the payload. The new instruction's ms_first cycle reads its own SRAM data.
- No SRAM request is issued while ms_allowin is low, so at most one read is outstanding.

## Configuration
- MYCPU_MEM_ADDR_CHECK_EN defined:
  - Misaligned accesses are H with a[0]=1, or W with a != 0.
  - Misaligned load: sets ms_adel; the SRAM read is still issued and its data is ignored.
  - Misaligned store: forces data_sram_wen = 0000 and sets ms_ades.
  - Both flags are registered with the payload.
- Undefined: no alignment check; ms_adel = ms_ades = 0 constantly; wen is formed from the shifted pattern as listed.

## Test plan
- SB, rt=0x12345678, addr=0x1003 -> data_sram_wen=1000, wdata=0x78787878, addr=0x1000, en=1 in the handover cycle.
- LB, rdata=0xAABBCCDD, addr a=2 -> ms_rdata=0x0000AABB one cycle after issue; ms_to_ws_valid=1.
- LW with ws_allowin=0 for 3 cycles after arrival, SRAM rdata changed to garbage -> ms_rdata holds the captured word and ms_allowin=0 throughout.
- SWL a=1, rt=0x11223344 -> wen=0011, wdata=0x00001122. SWR a=2, rt=0x11223344 -> wen=1100, wdata=0x33440000.
- With MYCPU_MEM_ADDR_CHECK_EN, SW addr=0x1002 -> wen=0000 and ms_ades=1 the next cycle. Without the macro -> wen=1111 and ms_ades=0.
- resetn=0 while ms_valid=1 -> ms_valid=0 and all outputs 0 after the edge; no data_sram_en pulse while resetn is low.

Source files
------------

// File: rtl/mycpu_mem_stage_if.sv
// Data-SRAM bus between the MEM stage (master) and the data memory (slave).
// Read data is valid exactly one cycle after an enabled read.
interface mycpu_mem_stage_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/mycpu_mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: MS register, data-SRAM request, load alignment.
// Optional alignment check (ms_adel/ms_ades, store suppression) under MYCPU_MEM_ADDR_CHECK_EN.
module mycpu_mem_stage (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      es_to_ms_valid,
  output logic                      ms_allowin,
  input  logic [31:0]               es_alu_result,
  input  logic [31:0]               es_store_data,
  input  logic [5:0]                es_mode,
  input  logic                      es_c5,
  input  logic [4:0]                es_dest,
  output logic                      ms_to_ws_valid,
  input  logic                      ws_allowin,
  output logic [31:0]               ms_alu_result,
  output logic [5:0]                ms_mode,
  output logic                      ms_c5,
  output logic [4:0]                ms_dest,
  output logic [31:0]               ms_rdata,
  output logic                      ms_adel,
  output logic                      ms_ades,
  mycpu_mem_stage_if.master         sram
);

  logic        r_ms_valid;
  logic        r_ms_first;
  logic [31:0] r_rdata_buf;
  logic [31:0] r_ms_alu_result;
  logic [5:0]  r_ms_mode;
  logic        r_ms_c5;
  logic [4:0]  r_ms_dest;

  logic        w_hs_in;
  logic [1:0]  w_a;
  logic [2:0]  w_size;
  logic        w_mis;
  logic [3:0]  w_wen_raw;
  logic [31:0] w_wdata;
  logic [31:0] w_raw;

  assign ms_allowin     = !r_ms_valid | ws_allowin;
  assign ms_to_ws_valid = r_ms_valid;
  assign w_hs_in        = es_to_ms_valid & ms_allowin;
  assign w_a            = es_alu_result[1:0];
  assign w_size         = es_mode[3:1];

`ifdef MYCPU_MEM_ADDR_CHECK_EN
  logic r_adel;
  logic r_ades;

  assign w_mis = ((w_size == 3'b001) & w_a[0]) | ((w_size == 3'b010) & (w_a != 2'b00));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_adel <= 1'b0;
      r_ades <= 1'b0;
    end else if (w_hs_in) begin
      r_adel <= es_mode[5] & w_mis;
      r_ades <= es_mode[4] & w_mis;
    end
  end

  assign ms_adel = r_ms_valid & r_adel;
  assign ms_ades = r_ms_valid & r_ades;
`else
  assign w_mis   = 1'b0;
  assign ms_adel = 1'b0;
  assign ms_ades = 1'b0;
`endif

  // Byte strobes and lane-replicated write data for each store size.
  always_comb begin
    w_wen_raw = 4'b0000;
    w_wdata   = 32'h0;
    case (w_size)
      3'b000: begin
        w_wen_raw = 4'b0001 << w_a;
        w_wdata   = {4{es_store_data[7:0]}};
      end
      3'b001: begin
        w_wen_raw = 4'b0011 << w_a;
        w_wdata   = {2{es_store_data[15:0]}};
      end
      3'b010: begin
        w_wen_raw = 4'b1111;
        w_wdata   = es_store_data;
      end
      3'b011: begin
        w_wen_raw = 4'b1111 >> (2'd3 - w_a);
        w_wdata   = es_store_data >> {2'd3 - w_a, 3'b000};
      end
      3'b100: begin
        w_wen_raw = 4'b1111 << w_a;
        w_wdata   = es_store_data << {w_a, 3'b000};
      end
      default: begin
        w_wen_raw = 4'b0000;
        w_wdata   = 32'h0;
      end
    endcase
  end

  // resetn gates the request so nothing reaches the SRAM while the pipe is being flushed.
  assign sram.data_sram_en    = w_hs_in & resetn & (es_mode[5] | es_mode[4]);
  assign sram.data_sram_wen   = (w_hs_in & resetn & es_mode[4] & !w_mis) ? w_wen_raw : 4'b0000;
  assign sram.data_sram_addr  = {es_alu_result[31:2], 2'b00};
  assign sram.data_sram_wdata = w_wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ms_valid      <= 1'b0;
      r_ms_first      <= 1'b0;
      r_rdata_buf     <= 32'h0;
      r_ms_alu_result <= 32'h0;
      r_ms_mode       <= 6'h0;
      r_ms_c5         <= 1'b0;
      r_ms_dest       <= 5'h0;
    end else begin
      if (w_hs_in) begin
        r_ms_valid <= 1'b1;
      end else if (ws_allowin) begin
        r_ms_valid <= 1'b0;
      end
      r_ms_first <= w_hs_in;
      if (r_ms_first) begin
        r_rdata_buf <= sram.data_sram_rdata;
      end
      if (w_hs_in) begin
        r_ms_alu_result <= es_alu_result;
        r_ms_mode       <= es_mode;
        r_ms_c5         <= es_c5;
        r_ms_dest       <= es_dest;
      end
    end
  end

  // Live SRAM data only in the first cycle; afterwards the captured copy holds through WB stalls.
  assign w_raw = r_ms_first ? sram.data_sram_rdata : r_rdata_buf;

  always_comb begin
    ms_rdata = 32'h0;
    if (r_ms_mode[5]) begin
      case (r_ms_mode[3:1])
        3'b000, 3'b001: ms_rdata = w_raw >> {r_ms_alu_result[1:0], 3'b000};
        default:        ms_rdata = w_raw;
      endcase
    end
  end

  assign ms_alu_result = r_ms_alu_result;
  assign ms_mode       = r_ms_mode;
  assign ms_c5         = r_ms_c5;
  assign ms_dest       = r_ms_dest;

endmodule

// File: tb/tb_mycpu_mem_stage.sv
// Self-checking bench for mycpu_mem_stage: scoreboard of expected load data, one task per scenario.
module tb_mycpu_mem_stage;

  localparam logic [5:0] ModeLb  = 6'b100001;
  localparam logic [5:0] ModeLbu = 6'b100000;
  localparam logic [5:0] ModeLh  = 6'b100011;
  localparam logic [5:0] ModeLw  = 6'b100100;
  localparam logic [5:0] ModeLwl = 6'b100110;
  localparam logic [5:0] ModeSb  = 6'b010000;
  localparam logic [5:0] ModeSh  = 6'b010010;
  localparam logic [5:0] ModeSw  = 6'b010100;
  localparam logic [5:0] ModeSwl = 6'b010110;
  localparam logic [5:0] ModeSwr = 6'b011000;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_alu_result;
  logic [31:0] es_store_data;
  logic [5:0]  es_mode;
  logic        es_c5;
  logic [4:0]  es_dest;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_alu_result;
  logic [5:0]  ms_mode;
  logic        ms_c5;
  logic [4:0]  ms_dest;
  logic [31:0] ms_rdata;
  logic        ms_adel;
  logic        ms_ades;

  logic [31:0] tb_rdval;
  logic        tb_garbage;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  dest;
  } exp_t;
  exp_t sb_q[$];

  mycpu_mem_stage_if u_bus ();

  mycpu_mem_stage u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .es_to_ms_valid (es_to_ms_valid),
    .ms_allowin     (ms_allowin),
    .es_alu_result  (es_alu_result),
    .es_store_data  (es_store_data),
    .es_mode        (es_mode),
    .es_c5          (es_c5),
    .es_dest        (es_dest),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ws_allowin     (ws_allowin),
    .ms_alu_result  (ms_alu_result),
    .ms_mode        (ms_mode),
    .ms_c5          (ms_c5),
    .ms_dest        (ms_dest),
    .ms_rdata       (ms_rdata),
    .ms_adel        (ms_adel),
    .ms_ades        (ms_ades),
    .sram           (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency SRAM: returns tb_rdval after an enabled access; may scribble while idle.
  always @(posedge clk) begin
    if (u_bus.data_sram_en) u_bus.data_sram_rdata <= tb_rdval;
    else if (tb_garbage) u_bus.data_sram_rdata <= $urandom;
  end

  task automatic drive(input logic v, input logic [5:0] mode, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] dest);
    es_to_ms_valid = v;
    es_mode        = mode;
    es_alu_result  = addr;
    es_store_data  = sd;
    es_dest        = dest;
    es_c5          = v;
  endtask

  task automatic test_reset;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", ms_to_ws_valid); end
    checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL rst_allowin got %b want 1", ms_allowin); end
    checks++; if (ms_alu_result !== 32'h0) begin failures++; $display("FAIL rst_alu got %h want 0", ms_alu_result); end
    checks++; if ({ms_mode, ms_c5, ms_dest} !== 12'h0) begin failures++; $display("FAIL rst_payload got %h want 0", {ms_mode, ms_c5, ms_dest}); end
    checks++; if (ms_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got %h want 0", ms_rdata); end
    checks++; if ({ms_adel, ms_ades} !== 2'b00) begin failures++; $display("FAIL rst_flags got %b want 00", {ms_adel, ms_ades}); end
    checks++; if (u_bus.data_sram_en !== 1'b0) begin failures++; $display("FAIL rst_en got %b want 0", u_bus.data_sram_en); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_store_sb;
    exp_t e;
    @(negedge clk);
    drive(1'b1, ModeSb, 32'h1003, 32'h12345678, 5'd3);
    #1;
    checks++; if (u_bus.data_sram_en !== 1'b1) begin failures++; $display("FAIL sb_en got %b want 1", u_bus.data_sram_en); end
    checks++; if (u_bus.data_sram_wen !== 4'b1000) begin failures++; $display("FAIL sb_wen got %b want 1000", u_bus.data_sram_wen); end
    checks++; if (u_bus.data_sram_wdata !== 32'h78787878) begin failures++; $display("FAIL sb_wdata got %h want 78787878", u_bus.data_sram_wdata); end
    checks++; if (u_bus.data_sram_addr !== 32'h1000) begin failures++; $display("FAIL sb_addr got %h want 00001000", u_bus.data_sram_addr); end
    sb_q.push_back('{32'h0, 5'd3});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++; if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL sb_valid got %b want 1", ms_to_ws_valid); end
    checks++; if (ms_alu_result !== 32'h1003) begin failures++; $display("FAIL sb_alu got %h want 00001003", ms_alu_result); end
    checks++; if (ms_c5 !== 1'b1 || ms_dest !== e.dest) begin failures++; $display("FAIL sb_dest got %b/%0d want 1/%0d", ms_c5, ms_dest, e.dest); end
    checks++; if (ms_rdata !== e.rdata) begin failures++; $display("FAIL sb_rdata got %h want %h", ms_rdata, e.rdata); end
    @(negedge clk);
    drive(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_load_lb;
    exp_t e;
    @(negedge clk);
    tb_rdval = 32'hAABBCCDD;
    drive(1'b1, ModeLb, 32'h2002, 32'h0, 5'd7);
    #1;
    checks++; if (u_bus.data_sram_en !== 1'b1 || u_bus.data_sram_wen !== 4'b0000) begin failures++; $display("FAIL lb_req got %b/%b want 1/0000", u_bus.data_sram_en, u_bus.data_sram_wen); end
    sb_q.push_back('{32'h0000AABB, 5'd7});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++; if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL lb_valid got %b want 1", ms_to_ws_valid); end
    checks++; if (ms_rdata !== e.rdata) begin failures++; $display("FAIL lb_rdata got %h want %h", ms_rdata, e.rdata); end
    checks++; if (ms_mode !== ModeLb || ms_dest !== e.dest) begin failures++; $display("FAIL lb_payload got %b/%0d want %b/%0d", ms_mode, ms_dest, ModeLb, e.dest); end
    @(negedge clk);
    drive(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_stall_back_to_back;
    exp_t e;
    @(negedge clk);
    ws_allowin = 1'b0;
    tb_rdval   = 32'hCAFEF00D;
    drive(1'b1, ModeLw, 32'h3000, 32'h0, 5'd9);
    #1;
    checks++; if (u_bus.data_sram_en !== 1'b1) begin failures++; $display("FAIL lw_en got %b want 1", u_bus.data_sram_en); end
    sb_q.push_back('{32'hCAFEF00D, 5'd9});
    @(posedge clk);
    #1;
    checks++; if (ms_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL lw_first got %h want cafef00d", ms_rdata); end
    @(negedge clk);
    tb_garbage = 1'b1;
    tb_rdval   = 32'h11223344;
    drive(1'b1, ModeLbu, 32'h3001, 32'h0, 5'd10);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (ms_allowin !== 1'b0 || u_bus.data_sram_en !== 1'b0) begin failures++; $display("FAIL stall_%0d allowin/en got %b/%b want 0/0", i, ms_allowin, u_bus.data_sram_en); end
      checks++; if (ms_rdata !== 32'hCAFEF00D || ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL stall_%0d rdata got %h want cafef00d", i, ms_rdata); end
    end
    @(negedge clk);
    ws_allowin = 1'b1;
    tb_garbage = 1'b0;
    #1;
    e = sb_q.pop_front();
    checks++; if (ms_rdata !== e.rdata || ms_dest !== e.dest) begin failures++; $display("FAIL lw_out got %h/%0d want %h/%0d", ms_rdata, ms_dest, e.rdata, e.dest); end
    checks++; if (ms_allowin !== 1'b1 || u_bus.data_sram_en !== 1'b1) begin failures++; $display("FAIL b2b_req allowin/en got %b/%b want 1/1", ms_allowin, u_bus.data_sram_en); end
    sb_q.push_back('{32'h00112233, 5'd10});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++; if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got %b want 1", ms_to_ws_valid); end
    checks++; if (ms_rdata !== e.rdata || ms_dest !== e.dest) begin failures++; $display("FAIL b2b_rdata got %h/%0d want %h/%0d", ms_rdata, ms_dest, e.rdata, e.dest); end
    @(negedge clk);
    drive(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
  endtask

  typedef struct {
    logic [5:0]  mode;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  task automatic test_mixed_stream;
    vec_t v[9];
    exp_t e;
    v[0] = '{ModeSwl, 32'h4001, 32'h11223344, 32'h0, 4'b0011, 32'h00001122, 32'h0};
    v[1] = '{ModeSwr, 32'h4002, 32'h11223344, 32'h0, 4'b1100, 32'h33440000, 32'h0};
    v[2] = '{ModeSh,  32'h5002, 32'hABCD1234, 32'h0, 4'b1100, 32'h12341234, 32'h0};
    v[3] = '{ModeSw,  32'h6000, 32'hDEADBEEF, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0};
    v[4] = '{ModeSb,  32'h7001, 32'h000000A5, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    v[5] = '{ModeLh,  32'h8002, 32'h0, 32'h87654321, 4'b0000, 32'h0, 32'h00008765};
    v[6] = '{ModeLw,  32'h8004, 32'h0, 32'h13579BDF, 4'b0000, 32'h0, 32'h13579BDF};
    v[7] = '{ModeLwl, 32'h8009, 32'h0, 32'h2468ACE0, 4'b0000, 32'h0, 32'h2468ACE0};
    v[8] = '{ModeLbu, 32'h800B, 32'h0, 32'h87654321, 4'b0000, 32'h0, 32'h00000087};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tb_rdval = v[i].rd;
      drive(1'b1, v[i].mode, v[i].addr, v[i].sd, 5'(i + 16));
      #1;
      checks++; if (u_bus.data_sram_en !== 1'b1 || u_bus.data_sram_wen !== v[i].wen) begin failures++; $display("FAIL vec%0d_wen got %b/%b want 1/%b", i, u_bus.data_sram_en, u_bus.data_sram_wen, v[i].wen); end
      if (v[i].mode[4]) begin
        checks++; if (u_bus.data_sram_wdata !== v[i].wdata) begin failures++; $display("FAIL vec%0d_wdata got %h want %h", i, u_bus.data_sram_wdata, v[i].wdata); end
      end
      sb_q.push_back('{v[i].rdata, 5'(i + 16)});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++; if (ms_rdata !== e.rdata || ms_dest !== e.dest) begin failures++; $display("FAIL vec%0d_rdata got %h/%0d want %h/%0d", i, ms_rdata, ms_dest, e.rdata, e.dest); end
      checks++; if (ms_alu_result !== v[i].addr) begin failures++; $display("FAIL vec%0d_alu got %h want %h", i, ms_alu_result, v[i].addr); end
    end
    @(negedge clk);
    drive(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_align;
    exp_t e;
    logic [3:0] exp_wen;
    logic       exp_flag;
`ifdef MYCPU_MEM_ADDR_CHECK_EN
    exp_wen  = 4'b0000;
    exp_flag = 1'b1;
`else
    exp_wen  = 4'b1111;
    exp_flag = 1'b0;
`endif
    @(negedge clk);
    drive(1'b1, ModeSw, 32'h1002, 32'h55AA55AA, 5'd4);
    #1;
    checks++; if (u_bus.data_sram_wen !== exp_wen) begin failures++; $display("FAIL mis_sw_wen got %b want %b", u_bus.data_sram_wen, exp_wen); end
    sb_q.push_back('{32'h0, 5'd4});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++; if (ms_ades !== exp_flag || ms_adel !== 1'b0) begin failures++; $display("FAIL mis_sw_flags got %b%b want 0%b", ms_adel, ms_ades, exp_flag); end
    checks++; if (ms_rdata !== e.rdata) begin failures++; $display("FAIL mis_sw_rdata got %h want %h", ms_rdata, e.rdata); end
    @(negedge clk);
    tb_rdval = 32'h0BADF00D;
    drive(1'b1, ModeLw, 32'h1001, 32'h0, 5'd5);
    #1;
    checks++; if (u_bus.data_sram_en !== 1'b1) begin failures++; $display("FAIL mis_lw_en got %b want 1", u_bus.data_sram_en); end
    @(posedge clk);
    #1;
    checks++; if (ms_adel !== exp_flag || ms_ades !== 1'b0) begin failures++; $display("FAIL mis_lw_flags got %b%b want %b0", ms_adel, ms_ades, exp_flag); end
    @(negedge clk);
    drive(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
    @(posedge clk);
    #1;
    checks++; if (ms_to_ws_valid !== 1'b0 || ms_adel !== 1'b0) begin failures++; $display("FAIL idle_flags got %b/%b want 0/0", ms_to_ws_valid, ms_adel); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    tb_rdval = 32'h12345678;
    drive(1'b1, ModeLw, 32'h8000, 32'h0, 5'd12);
    sb_q.push_back('{32'h12345678, 5'd12});
    @(posedge clk);
    #1;
    checks++; if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got %b want 1", ms_to_ws_valid); end
    @(negedge clk);
    resetn = 1'b0;
    drive(1'b1, ModeSw, 32'h8004, 32'hFFFFFFFF, 5'd13);
    #1;
    checks++; if (u_bus.data_sram_en !== 1'b0 || u_bus.data_sram_wen !== 4'b0000) begin failures++; $display("FAIL rmid_en got %b/%b want 0/0000", u_bus.data_sram_en, u_bus.data_sram_wen); end
    @(posedge clk);
    #1;
    sb_q.delete();
    checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got %b want 0", ms_to_ws_valid); end
    checks++; if ({ms_alu_result, ms_mode, ms_c5, ms_dest} !== 44'h0) begin failures++; $display("FAIL rmid_payload got %h want 0", {ms_alu_result, ms_mode, ms_c5, ms_dest}); end
    checks++; if (ms_rdata !== 32'h0 || {ms_adel, ms_ades} !== 2'b00) begin failures++; $display("FAIL rmid_rdata got %h/%b want 0/00", ms_rdata, {ms_adel, ms_ades}); end
    checks++; if (u_bus.data_sram_en !== 1'b0) begin failures++; $display("FAIL rmid_en2 got %b want 0", u_bus.data_sram_en); end
    @(negedge clk);
    drive(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    ws_allowin = 1'b1;
    tb_rdval   = 32'h0;
    tb_garbage = 1'b0;
    drive(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
    test_reset;
    test_store_sb;
    test_load_lb;
    test_stall_back_to_back;
    test_mixed_stream;
    test_align;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
